// File: rtl/cart_bank_mapper.sv
// cart_bank_mapper: cartridge bank register file with shadow/active register
// pairs, an atomic shadow->active commit FSM and a one-cycle registered
// address translator producing the masked bank number and space selects.
module cart_bank_mapper #(
  parameter int NUM_ROM_WIN = 2,
  parameter int BANK_W      = 10,
  parameter int RAM_MASK_W  = 4
) (
  input  logic              FastClk,
  input  logic              nReset,
  input  logic              RegWrite,
  input  logic              RegRead,
  input  logic [7:0]        RegAddr,
  input  logic [7:0]        RegWData,
  output logic [7:0]        RegRData,
  output logic              RegAck,
  input  logic              AccValid,
  input  logic [3:0]        AddrHi,
  input  logic              BusBusy,
  output logic              OutValid,
  output logic [BANK_W-1:0] BankOut,
  output logic              SelRom,
  output logic              SelRam,
  output logic              SelBoot,
  output logic              Pending
);

  // Width of the bank bits held in the "hi" registers (bits BANK_W-1:8).
  localparam int HI_W = BANK_W - 8;

  // Register map.
  localparam logic [7:0] A_LINEAR   = 8'hC0;
  localparam logic [7:0] A_RAM_LO0  = 8'hC1;
  localparam logic [7:0] A_RAM_LO1  = 8'hD0;
  localparam logic [7:0] A_RAM_HI   = 8'hD1;
  localparam logic [7:0] A_WIN0_ALT = 8'hC2;
  localparam logic [7:0] A_WIN1_ALT = 8'hC3;
  localparam logic [7:0] A_CTRL     = 8'hCE;
  localparam logic [7:0] A_ROMM_LO  = 8'hE4;
  localparam logic [7:0] A_ROMM_HI  = 8'hE5;
  localparam logic [7:0] A_RAMM     = 8'hE6;
  localparam logic [7:0] A_APPLY    = 8'hE7;
  localparam logic [7:0] A_COMMIT   = 8'hE8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PENDING,
    ST_COMMIT
  } commit_state_t;

  commit_state_t state_reg, state_next;
  logic          copy_en;

  // Control register (not shadowed).
  logic shadow_en_reg, shadow_en_next;
  logic self_flash_reg, self_flash_next;

  // Shadow/active pairs for the non-window registers.
  logic [7:0]             lin_sh_reg, lin_sh_next, lin_act_reg, lin_act_next;
  logic [BANK_W-1:0]      ram_sh_reg, ram_sh_next, ram_act_reg, ram_act_next;
  logic [BANK_W-1:0]      romm_sh_reg, romm_sh_next, romm_act_reg, romm_act_next;
  logic [RAM_MASK_W-1:0]  ramm_sh_reg, ramm_sh_next, ramm_act_reg, ramm_act_next;
  logic                   apr_sh_reg, apr_sh_next, apr_act_reg, apr_act_next;
  logic [NUM_ROM_WIN-1:0] apw_sh_reg, apw_sh_next, apw_act_reg, apw_act_next;

  // Window registers live in the generate loop; these expose them.
  logic [BANK_W-1:0]      win_sh  [NUM_ROM_WIN];
  logic [BANK_W-1:0]      win_act [NUM_ROM_WIN];
  logic [NUM_ROM_WIN-1:0] win_lo_hit;
  logic [NUM_ROM_WIN-1:0] win_hi_hit;

  // With shadowing off, writes land in the active set in the same edge.
  logic direct_wr;
  assign direct_wr = !shadow_en_reg;

  logic wr_commit;
  assign wr_commit = RegWrite && (RegAddr == A_COMMIT);

  // Commit FSM state register.
  always_ff @(posedge FastClk) begin
    if (!nReset) state_reg <= ST_IDLE;
    else         state_reg <= state_next;
  end

  // Commit FSM: wait for a quiet bus cycle, then copy shadow->active once.
  always_comb begin
    state_next = state_reg;
    copy_en    = 1'b0;
    case (state_reg)
      ST_IDLE:    if (wr_commit) state_next = ST_PENDING;
      ST_PENDING: if (!BusBusy && !AccValid) state_next = ST_COMMIT;
      ST_COMMIT: begin
        copy_en    = 1'b1;
        state_next = ST_IDLE;
      end
      default:    state_next = ST_IDLE;
    endcase
  end

  assign Pending = (state_reg != ST_IDLE);

  // Per-window shadow/active bank registers and their address decode.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_ROM_WIN; gi++) begin : g_win
      localparam logic [7:0] LO_ADDR = 8'(8'hD2 + 2 * gi);
      localparam logic [7:0] HI_ADDR = 8'(8'hD3 + 2 * gi);
      logic              alt_hit;
      logic [BANK_W-1:0] sh_reg, sh_next, act_reg, act_next;

      if (gi == 0) begin : g_alt0
        assign alt_hit = (RegAddr == A_WIN0_ALT);
      end else if (gi == 1) begin : g_alt1
        assign alt_hit = (RegAddr == A_WIN1_ALT);
      end else begin : g_noalt
        assign alt_hit = 1'b0;
      end

      assign win_lo_hit[gi] = (RegAddr == LO_ADDR) || alt_hit;
      assign win_hi_hit[gi] = (RegAddr == HI_ADDR);

      // Window next state: commit copy first, then direct byte writes win.
      always_comb begin
        sh_next  = sh_reg;
        act_next = copy_en ? sh_reg : act_reg;
        if (RegWrite && win_lo_hit[gi]) begin
          sh_next[7:0] = RegWData;
          if (direct_wr) act_next[7:0] = RegWData;
        end
        if (RegWrite && win_hi_hit[gi]) begin
          sh_next[BANK_W-1:8] = RegWData[HI_W-1:0];
          if (direct_wr) act_next[BANK_W-1:8] = RegWData[HI_W-1:0];
        end
      end

      // Window register storage, all-ones after reset.
      always_ff @(posedge FastClk) begin
        if (!nReset) begin
          sh_reg  <= '1;
          act_reg <= '1;
        end else begin
          sh_reg  <= sh_next;
          act_reg <= act_next;
        end
      end

      assign win_sh[gi]  = sh_reg;
      assign win_act[gi] = act_reg;
    end
  endgenerate

  // Non-window register next state: commit copy, then direct/shadow writes.
  // A write in the COMMIT cycle changes only the shadow (the copy uses the
  // pre-write shadow) unless shadowing is off, in which case it also lands.
  always_comb begin
    lin_sh_next     = lin_sh_reg;
    ram_sh_next     = ram_sh_reg;
    romm_sh_next    = romm_sh_reg;
    ramm_sh_next    = ramm_sh_reg;
    apr_sh_next     = apr_sh_reg;
    apw_sh_next     = apw_sh_reg;
    lin_act_next    = copy_en ? lin_sh_reg  : lin_act_reg;
    ram_act_next    = copy_en ? ram_sh_reg  : ram_act_reg;
    romm_act_next   = copy_en ? romm_sh_reg : romm_act_reg;
    ramm_act_next   = copy_en ? ramm_sh_reg : ramm_act_reg;
    apr_act_next    = copy_en ? apr_sh_reg  : apr_act_reg;
    apw_act_next    = copy_en ? apw_sh_reg  : apw_act_reg;
    shadow_en_next  = shadow_en_reg;
    self_flash_next = self_flash_reg;

    if (RegWrite) begin
      case (RegAddr)
        A_LINEAR: begin
          lin_sh_next = RegWData;
          if (direct_wr) lin_act_next = RegWData;
        end
        A_RAM_LO0, A_RAM_LO1: begin
          ram_sh_next[7:0] = RegWData;
          if (direct_wr) ram_act_next[7:0] = RegWData;
        end
        A_RAM_HI: begin
          ram_sh_next[BANK_W-1:8] = RegWData[HI_W-1:0];
          if (direct_wr) ram_act_next[BANK_W-1:8] = RegWData[HI_W-1:0];
        end
        A_CTRL: begin
          shadow_en_next  = RegWData[1];
          self_flash_next = RegWData[0];
        end
        A_ROMM_LO: begin
          romm_sh_next[7:0] = RegWData;
          if (direct_wr) romm_act_next[7:0] = RegWData;
        end
        A_ROMM_HI: begin
          romm_sh_next[BANK_W-1:8] = RegWData[HI_W-1:0];
          if (direct_wr) romm_act_next[BANK_W-1:8] = RegWData[HI_W-1:0];
        end
        A_RAMM: begin
          ramm_sh_next = RegWData[RAM_MASK_W-1:0];
          if (direct_wr) ramm_act_next = RegWData[RAM_MASK_W-1:0];
        end
        A_APPLY: begin
          apr_sh_next = RegWData[7];
          apw_sh_next = RegWData[NUM_ROM_WIN-1:0];
          if (direct_wr) begin
            apr_act_next = RegWData[7];
            apw_act_next = RegWData[NUM_ROM_WIN-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  // Non-window register storage; banks and masks reset to all-ones.
  always_ff @(posedge FastClk) begin
    if (!nReset) begin
      lin_sh_reg     <= '1;
      lin_act_reg    <= '1;
      ram_sh_reg     <= '1;
      ram_act_reg    <= '1;
      romm_sh_reg    <= '1;
      romm_act_reg   <= '1;
      ramm_sh_reg    <= '1;
      ramm_act_reg   <= '1;
      apr_sh_reg     <= 1'b1;
      apr_act_reg    <= 1'b1;
      apw_sh_reg     <= '1;
      apw_act_reg    <= '1;
      shadow_en_reg  <= 1'b0;
      self_flash_reg <= 1'b0;
    end else begin
      lin_sh_reg     <= lin_sh_next;
      lin_act_reg    <= lin_act_next;
      ram_sh_reg     <= ram_sh_next;
      ram_act_reg    <= ram_act_next;
      romm_sh_reg    <= romm_sh_next;
      romm_act_reg   <= romm_act_next;
      ramm_sh_reg    <= ramm_sh_next;
      ramm_act_reg   <= ramm_act_next;
      apr_sh_reg     <= apr_sh_next;
      apr_act_reg    <= apr_act_next;
      apw_sh_reg     <= apw_sh_next;
      apw_act_reg    <= apw_act_next;
      shadow_en_reg  <= shadow_en_next;
      self_flash_reg <= self_flash_next;
    end
  end

  // Linear bits above the bank width have no effect on translation.
  logic unused_lin_hi;
  assign unused_lin_hi = ^(lin_act_reg >> (BANK_W - 4));

  // Translation uses the active set as it stands before this edge.
  logic [BANK_W-1:0] xl_bank;
  logic              xl_rom, xl_ram, xl_boot;

  // Address translation: pick space, bank source and mask for AddrHi.
  always_comb begin
    xl_bank = '0;
    xl_rom  = 1'b0;
    xl_ram  = 1'b0;
    if (AddrHi == 4'd0) begin
      xl_bank = '0;
    end else if (AddrHi == 4'd1) begin
      xl_bank = ram_act_reg;
      if (apr_act_reg)
        xl_bank[RAM_MASK_W-1:0] = ram_act_reg[RAM_MASK_W-1:0] & ramm_act_reg;
      xl_rom = self_flash_reg;
      xl_ram = !self_flash_reg;
    end else if (int'(AddrHi) <= NUM_ROM_WIN + 1) begin
      for (int i = 0; i < NUM_ROM_WIN; i++) begin
        if (int'(AddrHi) == i + 2)
          xl_bank = win_act[i] & (apw_act_reg[i] ? romm_act_reg : {BANK_W{1'b1}});
      end
      xl_rom = 1'b1;
    end else begin
      xl_bank = {lin_act_reg[BANK_W-5:0], AddrHi} & romm_act_reg;
      xl_rom  = 1'b1;
    end
    xl_boot = xl_rom && (xl_bank == {BANK_W{1'b1}});
  end

  // Translation output register; idle cycles drive clean zeros.
  always_ff @(posedge FastClk) begin
    if (!nReset) begin
      OutValid <= 1'b0;
      BankOut  <= '0;
      SelRom   <= 1'b0;
      SelRam   <= 1'b0;
      SelBoot  <= 1'b0;
    end else begin
      OutValid <= AccValid;
      BankOut  <= AccValid ? xl_bank : '0;
      SelRom   <= AccValid && xl_rom;
      SelRam   <= AccValid && xl_ram;
      SelBoot  <= AccValid && xl_boot;
    end
  end

  // Register read mux; reads always see the shadow copy.
  logic [7:0] rd_data;
  logic       rd_hit;

  // Read decode: fixed registers by case, windows by the decode vectors.
  always_comb begin
    rd_data = '0;
    rd_hit  = 1'b1;
    case (RegAddr)
      A_LINEAR:             rd_data = lin_sh_reg;
      A_RAM_LO0, A_RAM_LO1: rd_data = ram_sh_reg[7:0];
      A_RAM_HI:             rd_data = 8'(ram_sh_reg[BANK_W-1:8]);
      A_CTRL:               rd_data = {6'b0, shadow_en_reg, self_flash_reg};
      A_ROMM_LO:            rd_data = romm_sh_reg[7:0];
      A_ROMM_HI:            rd_data = 8'(romm_sh_reg[BANK_W-1:8]);
      A_RAMM:               rd_data = 8'(ramm_sh_reg);
      A_APPLY: begin
        rd_data[7]               = apr_sh_reg;
        rd_data[NUM_ROM_WIN-1:0] = apw_sh_reg;
      end
      A_COMMIT:             rd_data = {7'b0, Pending};
      default:              rd_hit  = 1'b0;
    endcase
    for (int i = 0; i < NUM_ROM_WIN; i++) begin
      if (win_lo_hit[i]) begin
        rd_hit  = 1'b1;
        rd_data = win_sh[i][7:0];
      end
      if (win_hi_hit[i]) begin
        rd_hit  = 1'b1;
        rd_data = 8'(win_sh[i][BANK_W-1:8]);
      end
    end
  end

  // Read response register: acknowledge only mapped addresses.
  always_ff @(posedge FastClk) begin
    if (!nReset) begin
      RegAck   <= 1'b0;
      RegRData <= '0;
    end else begin
      RegAck   <= RegRead && rd_hit;
      RegRData <= (RegRead && rd_hit) ? rd_data : 8'h00;
    end
  end

endmodule

// File: tb/tb_cart_bank_mapper.sv
// Self-checking bench for cart_bank_mapper (default parameters).
// Expected translation and read results are queued as stimulus is driven
// and popped when the DUT's registered outputs appear.
module tb_cart_bank_mapper;

  logic       FastClk = 1'b0;
  logic       nReset;
  logic       RegWrite, RegRead;
  logic [7:0] RegAddr, RegWData;
  logic [7:0] RegRData;
  logic       RegAck;
  logic       AccValid;
  logic [3:0] AddrHi;
  logic       BusBusy;
  logic       OutValid;
  logic [9:0] BankOut;
  logic       SelRom, SelRam, SelBoot, Pending;

  int errors = 0;
  int checks = 0;

  // {OutValid, BankOut, SelRom, SelRam, SelBoot}
  logic [13:0] acc_q[$];
  // {RegAck, RegRData}
  logic [8:0]  rd_q[$];

  cart_bank_mapper dut (
    .FastClk (FastClk),
    .nReset  (nReset),
    .RegWrite(RegWrite),
    .RegRead (RegRead),
    .RegAddr (RegAddr),
    .RegWData(RegWData),
    .RegRData(RegRData),
    .RegAck  (RegAck),
    .AccValid(AccValid),
    .AddrHi  (AddrHi),
    .BusBusy (BusBusy),
    .OutValid(OutValid),
    .BankOut (BankOut),
    .SelRom  (SelRom),
    .SelRam  (SelRam),
    .SelBoot (SelBoot),
    .Pending (Pending)
  );

  always #5 FastClk = ~FastClk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "time limit");
  end

  // sel = {rom, ram, boot}
  function automatic logic [13:0] acc(input logic [9:0] bank, input logic [2:0] sel);
    return {1'b1, bank, sel};
  endfunction

  task automatic tick();
    @(posedge FastClk);
    #1;
  endtask

  task automatic reg_write(input logic [7:0] a, input logic [7:0] d);
    RegWrite = 1'b1; RegAddr = a; RegWData = d;
    tick();
    RegWrite = 1'b0;
  endtask

  task automatic reg_read(input logic [7:0] a, input logic [8:0] exp);
    rd_q.push_back(exp);
    RegRead = 1'b1; RegAddr = a;
    tick();
    RegRead = 1'b0;
  endtask

  task automatic test_reset();
    logic [23:0] obs;
    logic [13:0] ao, ae;
    logic [8:0]  ro, re;
    logic [3:0]  ah [4];
    logic [13:0] ex [4];
    nReset = 1'b0; AccValid = 1'b1; AddrHi = 4'd2; RegRead = 1'b1; RegAddr = 8'hC2;
    tick(); tick();
    obs = {OutValid, BankOut, SelRom, SelRam, SelBoot, RegAck, RegRData, Pending};
    checks++;
    if (obs !== 24'h0) begin errors++; $display("FAIL reset_outputs: got %h want 000000", obs); end
    AccValid = 1'b0; RegRead = 1'b0; nReset = 1'b1;
    tick();
    reg_read(8'hC2, {1'b1, 8'hFF});
    ro = {RegAck, RegRData}; re = rd_q.pop_front(); checks++;
    if (ro !== re) begin errors++; $display("FAIL reset_read_c2: got %h want %h", ro, re); end
    ah[0] = 4'd2;  ex[0] = acc(10'h3FF, 3'b101);
    ah[1] = 4'd3;  ex[1] = acc(10'h3FF, 3'b101);
    ah[2] = 4'd15; ex[2] = acc(10'h3FF, 3'b101);
    ah[3] = 4'd4;  ex[3] = acc(10'h3F4, 3'b100);
    for (int i = 0; i < 4; i++) begin
      acc_q.push_back(ex[i]);
      AccValid = 1'b1; AddrHi = ah[i];
      tick();
      ao = {OutValid, BankOut, SelRom, SelRam, SelBoot}; ae = acc_q.pop_front(); checks++;
      if (ao !== ae) begin errors++; $display("FAIL reset_acc_%0d: got %h want %h", ah[i], ao, ae); end
    end
    AccValid = 1'b0;
  endtask

  task automatic test_direct_write();
    logic [13:0] ao, ae;
    logic [8:0]  ro, re;
    logic [7:0]  ra [2];
    logic [8:0]  rx [2];
    reg_write(8'hD2, 8'h12);
    reg_write(8'hD3, 8'h01);
    acc_q.push_back(acc(10'h112, 3'b100));
    AccValid = 1'b1; AddrHi = 4'd2;
    tick();
    AccValid = 1'b0;
    ao = {OutValid, BankOut, SelRom, SelRam, SelBoot}; ae = acc_q.pop_front(); checks++;
    if (ao !== ae) begin errors++; $display("FAIL direct_acc_w0: got %h want %h", ao, ae); end
    ra[0] = 8'hD3; rx[0] = {1'b1, 8'h01};
    ra[1] = 8'hD2; rx[1] = {1'b1, 8'h12};
    for (int i = 0; i < 2; i++) begin
      reg_read(ra[i], rx[i]);
      ro = {RegAck, RegRData}; re = rd_q.pop_front(); checks++;
      if (ro !== re) begin errors++; $display("FAIL direct_read_%h: got %h want %h", ra[i], ro, re); end
    end
  endtask

  task automatic test_same_cycle();
    logic [13:0] ao, ae;
    acc_q.push_back(acc(10'h112, 3'b100));
    RegWrite = 1'b1; RegAddr = 8'hD2; RegWData = 8'h44;
    AccValid = 1'b1; AddrHi = 4'd2;
    tick();
    RegWrite = 1'b0;
    ao = {OutValid, BankOut, SelRom, SelRam, SelBoot}; ae = acc_q.pop_front(); checks++;
    if (ao !== ae) begin errors++; $display("FAIL same_cycle_prewrite: got %h want %h", ao, ae); end
    acc_q.push_back(acc(10'h144, 3'b100));
    tick();
    AccValid = 1'b0;
    ao = {OutValid, BankOut, SelRom, SelRam, SelBoot}; ae = acc_q.pop_front(); checks++;
    if (ao !== ae) begin errors++; $display("FAIL same_cycle_postwrite: got %h want %h", ao, ae); end
    reg_write(8'hD2, 8'h12);
  endtask

  task automatic test_shadow_commit();
    logic [13:0] ao, ae;
    logic [8:0]  ro, re;
    int n;
    reg_write(8'hCE, 8'h02);
    reg_write(8'hC2, 8'h05);
    acc_q.push_back(acc(10'h112, 3'b100));
    AccValid = 1'b1; AddrHi = 4'd2;
    tick();
    AccValid = 1'b0;
    ao = {OutValid, BankOut, SelRom, SelRam, SelBoot}; ae = acc_q.pop_front(); checks++;
    if (ao !== ae) begin errors++; $display("FAIL shadow_hidden: got %h want %h", ao, ae); end
    reg_read(8'hC2, {1'b1, 8'h05});
    ro = {RegAck, RegRData}; re = rd_q.pop_front(); checks++;
    if (ro !== re) begin errors++; $display("FAIL shadow_read_c2: got %h want %h", ro, re); end
    BusBusy = 1'b1;
    reg_write(8'hE8, 8'h00);
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (Pending !== 1'b1) begin errors++; $display("FAIL busy_hold_%0d: Pending got %b want 1", i, Pending); end
    end
    reg_read(8'hE8, {1'b1, 8'h01});
    ro = {RegAck, RegRData}; re = rd_q.pop_front(); checks++;
    if (ro !== re) begin errors++; $display("FAIL pending_read_e8: got %h want %h", ro, re); end
    reg_write(8'hD4, 8'h07);
    BusBusy = 1'b0;
    n = 0;
    while (Pending === 1'b1 && n < 8) begin tick(); n++; end
    checks++;
    if (n != 2 || Pending !== 1'b0) begin
      errors++; $display("FAIL commit_latency: cycles got %0d want 2, Pending %b", n, Pending);
    end
    acc_q.push_back(acc(10'h105, 3'b100));
    AccValid = 1'b1; AddrHi = 4'd2;
    tick();
    ao = {OutValid, BankOut, SelRom, SelRam, SelBoot}; ae = acc_q.pop_front(); checks++;
    if (ao !== ae) begin errors++; $display("FAIL commit_w0: got %h want %h", ao, ae); end
    acc_q.push_back(acc(10'h307, 3'b100));
    AddrHi = 4'd3;
    tick();
    AccValid = 1'b0;
    ao = {OutValid, BankOut, SelRom, SelRam, SelBoot}; ae = acc_q.pop_front(); checks++;
    if (ao !== ae) begin errors++; $display("FAIL commit_w1_pending_write: got %h want %h", ao, ae); end
  endtask

  task automatic test_back_to_back();
    logic [13:0] ao, ae;
    int n;
    reg_write(8'hC2, 8'h12);
    reg_write(8'hE8, 8'h00);
    for (int i = 0; i < 3; i++) begin
      acc_q.push_back(acc(10'h105, 3'b100));
      AccValid = 1'b1; AddrHi = 4'd2;
      tick();
      ao = {OutValid, BankOut, SelRom, SelRam, SelBoot}; ae = acc_q.pop_front(); checks++;
      if (ao !== ae) begin errors++; $display("FAIL b2b_acc_%0d: got %h want %h", i, ao, ae); end
    end
    AccValid = 1'b0;
    checks++;
    if (Pending !== 1'b1) begin errors++; $display("FAIL acc_blocks_commit: Pending got %b want 1", Pending); end
    n = 0;
    while (Pending === 1'b1 && n < 8) begin tick(); n++; end
    checks++;
    if (n != 2 || Pending !== 1'b0) begin
      errors++; $display("FAIL b2b_commit_latency: cycles got %0d want 2, Pending %b", n, Pending);
    end
    acc_q.push_back(acc(10'h112, 3'b100));
    AccValid = 1'b1; AddrHi = 4'd2;
    tick();
    AccValid = 1'b0;
    ao = {OutValid, BankOut, SelRom, SelRam, SelBoot}; ae = acc_q.pop_front(); checks++;
    if (ao !== ae) begin errors++; $display("FAIL b2b_after_commit: got %h want %h", ao, ae); end
  endtask

  task automatic test_masking();
    logic [13:0] ao, ae;
    logic [8:0]  ro, re;
    logic [3:0]  ah [9];
    logic [13:0] ex [9];
    logic [7:0]  ra [3];
    logic [8:0]  rx [3];
    reg_write(8'hCE, 8'h00);
    reg_write(8'hE4, 8'h0F);
    reg_write(8'hE5, 8'h00);
    ah[0] = 4'd2;  ex[0] = acc(10'h002, 3'b100);
    ah[1] = 4'd3;  ex[1] = acc(10'h007, 3'b100);
    ah[2] = 4'd4;  ex[2] = acc(10'h004, 3'b100);
    ah[3] = 4'd0;  ex[3] = acc(10'h000, 3'b000);
    ah[4] = 4'd15; ex[4] = acc(10'h00F, 3'b100);
    for (int i = 0; i < 5; i++) begin
      acc_q.push_back(ex[i]);
      AccValid = 1'b1; AddrHi = ah[i];
      tick();
      ao = {OutValid, BankOut, SelRom, SelRam, SelBoot}; ae = acc_q.pop_front(); checks++;
      if (ao !== ae) begin errors++; $display("FAIL mask_on_%0d: got %h want %h", ah[i], ao, ae); end
    end
    AccValid = 1'b0;
    reg_write(8'hE7, 8'h80);
    ah[5] = 4'd2; ex[5] = acc(10'h112, 3'b100);
    ah[6] = 4'd3; ex[6] = acc(10'h307, 3'b100);
    ah[7] = 4'd4; ex[7] = acc(10'h004, 3'b100);
    ah[8] = 4'd9; ex[8] = acc(10'h009, 3'b100);
    for (int i = 5; i < 9; i++) begin
      acc_q.push_back(ex[i]);
      AccValid = 1'b1; AddrHi = ah[i];
      tick();
      ao = {OutValid, BankOut, SelRom, SelRam, SelBoot}; ae = acc_q.pop_front(); checks++;
      if (ao !== ae) begin errors++; $display("FAIL mask_off_%0d: got %h want %h", ah[i], ao, ae); end
    end
    AccValid = 1'b0;
    ra[0] = 8'hE7; rx[0] = {1'b1, 8'h80};
    ra[1] = 8'hE5; rx[1] = {1'b1, 8'h00};
    ra[2] = 8'hE4; rx[2] = {1'b1, 8'h0F};
    for (int i = 0; i < 3; i++) begin
      reg_read(ra[i], rx[i]);
      ro = {RegAck, RegRData}; re = rd_q.pop_front(); checks++;
      if (ro !== re) begin errors++; $display("FAIL mask_read_%h: got %h want %h", ra[i], ro, re); end
    end
  endtask

  task automatic test_ram();
    logic [13:0] ao, ae;
    logic [8:0]  ro, re;
    logic [7:0]  ra [3];
    logic [8:0]  rx [3];
    reg_write(8'hCE, 8'h01);
    acc_q.push_back(acc(10'h3FF, 3'b101));
    AccValid = 1'b1; AddrHi = 4'd1;
    tick();
    AccValid = 1'b0;
    ao = {OutValid, BankOut, SelRom, SelRam, SelBoot}; ae = acc_q.pop_front(); checks++;
    if (ao !== ae) begin errors++; $display("FAIL ram_self_flash: got %h want %h", ao, ae); end
    reg_write(8'hCE, 8'h00);
    acc_q.push_back(acc(10'h3FF, 3'b010));
    AccValid = 1'b1; AddrHi = 4'd1;
    tick();
    AccValid = 1'b0;
    ao = {OutValid, BankOut, SelRom, SelRam, SelBoot}; ae = acc_q.pop_front(); checks++;
    if (ao !== ae) begin errors++; $display("FAIL ram_select: got %h want %h", ao, ae); end
    reg_write(8'hC1, 8'h0F);
    reg_write(8'hD1, 8'h00);
    reg_write(8'hE6, 8'h03);
    acc_q.push_back(acc(10'h003, 3'b010));
    AccValid = 1'b1; AddrHi = 4'd1;
    tick();
    AccValid = 1'b0;
    ao = {OutValid, BankOut, SelRom, SelRam, SelBoot}; ae = acc_q.pop_front(); checks++;
    if (ao !== ae) begin errors++; $display("FAIL ram_masked: got %h want %h", ao, ae); end
    reg_write(8'hD1, 8'h02);
    acc_q.push_back(acc(10'h203, 3'b010));
    AccValid = 1'b1; AddrHi = 4'd1;
    tick();
    AccValid = 1'b0;
    ao = {OutValid, BankOut, SelRom, SelRam, SelBoot}; ae = acc_q.pop_front(); checks++;
    if (ao !== ae) begin errors++; $display("FAIL ram_upper_pass: got %h want %h", ao, ae); end
    ra[0] = 8'hD0; rx[0] = {1'b1, 8'h0F};
    ra[1] = 8'hD1; rx[1] = {1'b1, 8'h02};
    ra[2] = 8'hE6; rx[2] = {1'b1, 8'h03};
    for (int i = 0; i < 3; i++) begin
      reg_read(ra[i], rx[i]);
      ro = {RegAck, RegRData}; re = rd_q.pop_front(); checks++;
      if (ro !== re) begin errors++; $display("FAIL ram_read_%h: got %h want %h", ra[i], ro, re); end
    end
    reg_write(8'hE7, 8'h00);
    acc_q.push_back(acc(10'h20F, 3'b010));
    AccValid = 1'b1; AddrHi = 4'd1;
    tick();
    AccValid = 1'b0;
    ao = {OutValid, BankOut, SelRom, SelRam, SelBoot}; ae = acc_q.pop_front(); checks++;
    if (ao !== ae) begin errors++; $display("FAIL ram_unmasked: got %h want %h", ao, ae); end
  endtask

  task automatic test_reset_pending();
    logic [13:0] ao, ae;
    logic [8:0]  ro, re;
    logic [7:0]  ra [6];
    logic [8:0]  rx [6];
    reg_write(8'hCE, 8'h02);
    reg_write(8'hC2, 8'h33);
    BusBusy = 1'b1;
    reg_write(8'hE8, 8'h00);
    checks++;
    if (Pending !== 1'b1) begin errors++; $display("FAIL rp_pending_set: Pending got %b want 1", Pending); end
    nReset = 1'b0;
    tick();
    checks++;
    if ({Pending, OutValid, RegAck} !== 3'b000) begin
      errors++; $display("FAIL rp_in_reset: {Pending,OutValid,RegAck} got %b want 000", {Pending, OutValid, RegAck});
    end
    nReset = 1'b1; BusBusy = 1'b0;
    tick();
    checks++;
    if (Pending !== 1'b0) begin errors++; $display("FAIL rp_after_reset: Pending got %b want 0", Pending); end
    ra[0] = 8'hC2; rx[0] = {1'b1, 8'hFF};
    ra[1] = 8'hD3; rx[1] = {1'b1, 8'h03};
    ra[2] = 8'hAA; rx[2] = {1'b0, 8'h00};
    ra[3] = 8'hCE; rx[3] = {1'b1, 8'h00};
    ra[4] = 8'hE7; rx[4] = {1'b1, 8'h83};
    ra[5] = 8'hE8; rx[5] = {1'b1, 8'h00};
    for (int i = 0; i < 6; i++) begin
      reg_read(ra[i], rx[i]);
      ro = {RegAck, RegRData}; re = rd_q.pop_front(); checks++;
      if (ro !== re) begin errors++; $display("FAIL rp_read_%h: got %h want %h", ra[i], ro, re); end
    end
    acc_q.push_back(acc(10'h3FF, 3'b101));
    AccValid = 1'b1; AddrHi = 4'd2;
    tick();
    AccValid = 1'b0;
    ao = {OutValid, BankOut, SelRom, SelRam, SelBoot}; ae = acc_q.pop_front(); checks++;
    if (ao !== ae) begin errors++; $display("FAIL rp_acc_w0: got %h want %h", ao, ae); end
  endtask

  initial begin
    nReset = 1'b0; RegWrite = 1'b0; RegRead = 1'b0; RegAddr = 8'h00; RegWData = 8'h00;
    AccValid = 1'b0; AddrHi = 4'd0; BusBusy = 1'b0;
    test_reset();
    test_direct_write();
    test_same_cycle();
    test_shadow_commit();
    test_back_to_back();
    test_masking();
    test_ram();
    test_reset_pending();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
